// File: rtl/paper_pkg.sv
// Shared opcodes, FSM states and instruction-field helpers for the paper processor.
// PC_SEQ_SINGLE_STEP_EN adds the STEPWAIT state used for single stepping.
package paper_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_JNO  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int INSTR_W = 4;
  localparam int OPC_HI  = 3;
  localparam int OPC_LO  = 2;
  localparam int OPD_HI  = 1;
  localparam int OPD_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_PULSE    = 3'd3,
    ST_WB       = 3'd4,
`ifdef PC_SEQ_SINGLE_STEP_EN
    ST_STEPWAIT = 3'd6,
`endif
    ST_HALTED   = 3'd5
  } state_e;

  function automatic logic [1:0] instr_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [1:0] instr_operand(input logic [INSTR_W-1:0] word);
    return word[OPD_HI:OPD_LO];
  endfunction

endpackage

// File: rtl/pulse_gen.sv
// Bounded strobe generator: load starts a PULSE_W-clock high strobe; done marks its
// last clock so the caller can leave on the same edge the strobe drops.
module pulse_gen #(
  parameter int PULSE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic pulse,
  output logic done
);

  localparam int CNT_W = (PULSE_W < 2) ? 1 : $clog2(PULSE_W + 1);

  logic [CNT_W-1:0] count_r;
  logic             pulse_r;

  // down-counter with registered strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      pulse_r <= 1'b0;
    end else if (load) begin
      count_r <= CNT_W'(PULSE_W);
      pulse_r <= 1'b1;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1'b1);
      pulse_r <= (count_r != CNT_W'(1'b1));
    end else begin
      count_r <= count_r;
      pulse_r <= 1'b0;
    end
  end

  assign pulse = pulse_r;
  assign done  = (count_r == CNT_W'(1'b1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for the paper processor: pc, accumulator, INC strobe and JNO/HALT.
// Define PC_SEQ_SINGLE_STEP_EN to add the step input and the STEPWAIT gate before every fetch.
module pc_sequencer
  import paper_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int PULSE_W = 2,
  parameter int PC_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        instr,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] adder_sum,
  input  logic              adder_cout,
  output logic              inc_pulse,
  output logic              status,
  output logic              busy,
  output logic              halted
);

`ifdef PC_SEQ_SINGLE_STEP_EN
  localparam state_e FETCH_ENTRY = ST_STEPWAIT;
`else
  localparam state_e FETCH_ENTRY = ST_FETCH;
`endif

  state_e              state_r, state_nxt_s;
  logic [PC_W-1:0]     pc_r, pc_nxt_s, pc_inc_s;
  logic [DATA_W-1:0]   acc_r, acc_nxt_s;
  logic                status_r, status_nxt_s;
  logic [3:0]          ir_r, ir_nxt_s;
  logic                busy_r, halted_r;
  logic                pulse_load_s, pulse_done_s;

  assign pc_inc_s = pc_r + PC_W'(1'b1);

  pulse_gen #(.PULSE_W(PULSE_W)) u_pulse_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pulse_load_s),
    .pulse (inc_pulse),
    .done  (pulse_done_s)
  );

  // next-state and datapath update
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    acc_nxt_s    = acc_r;
    status_nxt_s = status_r;
    ir_nxt_s     = ir_r;
    pulse_load_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_nxt_s    = {PC_W{1'b0}};
          state_nxt_s = FETCH_ENTRY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH: begin
        ir_nxt_s    = instr;
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        case (instr_opcode(ir_r))
          OP_INC: begin
            pulse_load_s = 1'b1;
            state_nxt_s  = ST_PULSE;
          end
          OP_CLR: begin
            acc_nxt_s    = {DATA_W{1'b0}};
            status_nxt_s = 1'b0;
            pc_nxt_s     = pc_inc_s;
            state_nxt_s  = FETCH_ENTRY;
          end
          OP_JNO: begin
            pc_nxt_s    = status_r ? pc_inc_s : PC_W'(instr_operand(ir_r));
            state_nxt_s = FETCH_ENTRY;
          end
          OP_HALT: begin
            state_nxt_s = ST_HALTED;
          end
          default: begin
            state_nxt_s = ST_HALTED;
          end
        endcase
      end
      ST_PULSE: begin
        if (pulse_done_s) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_PULSE;
        end
      end
      ST_WB: begin
        acc_nxt_s    = adder_sum;
        status_nxt_s = adder_cout;
        pc_nxt_s     = pc_inc_s;
        state_nxt_s  = FETCH_ENTRY;
      end
`ifdef PC_SEQ_SINGLE_STEP_EN
      ST_STEPWAIT: begin
        if (step) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_STEPWAIT;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PC_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      status_r <= 1'b0;
      ir_r     <= 4'b0000;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      acc_r    <= acc_nxt_s;
      status_r <= status_nxt_s;
      ir_r     <= ir_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HALTED);
      halted_r <= (state_nxt_s == ST_HALTED);
    end
  end

  assign pc     = pc_r;
  assign acc    = acc_r;
  assign status = status_r;
  assign busy   = busy_r;
  assign halted = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed programs plus random programs, compared every
// clock against an instruction-level timing model. Honours PC_SEQ_SINGLE_STEP_EN when defined.
module tb_pc_sequencer;

  localparam int DATA_W  = 2;
  localparam int PULSE_W = 2;
  localparam int PC_W    = 2;
  localparam int NPC     = 1 << PC_W;
  localparam int NACC    = 1 << DATA_W;

  localparam logic [3:0] W_INC  = 4'b0000;
  localparam logic [3:0] W_CLR  = 4'b0100;
  localparam logic [3:0] W_JNO0 = 4'b1000;
  localparam logic [3:0] W_HALT = 4'b1100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
  logic              step = 1'b0;
`endif
  logic [3:0]        instr;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc, adder_sum;
  logic              adder_cout, inc_pulse, status, busy, halted;

  logic [3:0] prog [NPC];

  int n_vec  = 0;
  int n_miss = 0;

  // instruction-level model state
  int m_pc, m_acc, m_st, m_run, m_halt, m_ph, m_op, m_opd, m_wait;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, acc} + (DATA_W + 1)'(1);
  assign instr = prog[pc];

  pc_sequencer #(.DATA_W(DATA_W), .PULSE_W(PULSE_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef PC_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .instr      (instr),
    .pc         (pc),
    .acc        (acc),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .inc_pulse  (inc_pulse),
    .status     (status),
    .busy       (busy),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int op_len(input int op);
    return (op == 0) ? 3 + PULSE_W : 2;
  endfunction

  function automatic int model_pulse();
    return (m_run != 0 && m_wait == 0 && m_op == 0 && m_ph >= 2 && m_ph < 2 + PULSE_W) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_st = 0; m_run = 0; m_halt = 0;
    m_ph = 0; m_op = 0; m_opd = 0; m_wait = 0;
  endtask

  task automatic enter_fetch();
    m_ph = 0;
`ifdef PC_SEQ_SINGLE_STEP_EN
    m_wait = 1;
`endif
  endtask

  // one rising edge of the reference machine
  task automatic model_edge(input logic st, input logic stp);
    if (m_run == 0) begin
      if (st) begin
        m_pc = 0; m_run = 1; m_halt = 0;
        enter_fetch();
      end
    end else if (m_wait != 0) begin
      if (stp) begin
        m_wait = 0;
        m_ph = 0;
      end
    end else begin
      if (m_ph == 0) begin
        m_op  = int'(prog[m_pc][3:2]);
        m_opd = int'(prog[m_pc][1:0]);
      end
      m_ph++;
      if (m_ph == op_len(m_op)) begin
        case (m_op)
          0: begin
            m_acc = m_acc + 1;
            m_st  = (m_acc == NACC) ? 1 : 0;
            m_acc = m_acc % NACC;
            m_pc  = (m_pc + 1) % NPC;
          end
          1: begin
            m_acc = 0; m_st = 0;
            m_pc  = (m_pc + 1) % NPC;
          end
          2: m_pc = (m_st != 0) ? (m_pc + 1) % NPC : m_opd % NPC;
          default: begin
            m_run = 0; m_halt = 1;
          end
        endcase
        if (m_run != 0) enter_fetch();
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("acc", acc, m_acc);
    check("status", status, m_st);
    check("inc_pulse", inc_pulse, model_pulse());
    check("busy", busy, m_run);
    check("halted", halted, m_halt);
  endtask

  task automatic tick(input logic st, input logic stp);
    @(negedge clk);
    start = st;
`ifdef PC_SEQ_SINGLE_STEP_EN
    step = stp;
`endif
    @(posedge clk);
    model_edge(st, stp);
    #1;
    compare_all();
  endtask

  task automatic load_prog(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    load_prog(W_INC, W_INC, W_INC, W_HALT);
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // INC,INC,INC,HALT from acc=0; random start pulses while busy must be ignored
    tick(1'b1, 1'b1);
    for (int i = 0; i < 17; i++) tick(1'($urandom_range(0, 1)), 1'b1);
`ifndef PC_SEQ_SINGLE_STEP_EN
    check("plan_acc", acc, 3);
    check("plan_status", status, 0);
    check("plan_halted", halted, 1);
    check("plan_pc", pc, 3);
`endif
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);

    // restart from HALTED, then reset in the middle of the INC strobe
    load_prog(W_INC, W_CLR, W_CLR, W_CLR);
    tick(1'b1, 1'b1);
    check("restart_pc", pc, 0);
    check("restart_halted", halted, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (model_pulse() != 0) found = 1'b1;
    end
    check("pulse_seen", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check("rst_pulse", inc_pulse, 0);
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_status", status, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // overflow after four INCs, then JNO falls through, CLR, JNO jumps
    load_prog(W_INC, W_INC, W_INC, W_INC);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4 * (3 + PULSE_W); i++) tick(1'($urandom_range(0, 1)), 1'b1);
`ifndef PC_SEQ_SINGLE_STEP_EN
    check("ovf_acc", acc, 0);
    check("ovf_status", status, 1);
    load_prog(W_JNO0, W_CLR, W_JNO0, W_HALT);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    check("jno_fall_pc", pc, 1);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    check("clr_status", status, 0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    check("jno_jump_pc", pc, 0);
`endif
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);

    // pc wrap through CLR x4
    do_reset();
    load_prog(W_CLR, W_CLR, W_CLR, W_CLR);
    tick(1'b1, 1'b1);
`ifndef PC_SEQ_SINGLE_STEP_EN
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      check("wrap_pc", pc, k % NPC);
      check("wrap_busy", busy, 1);
    end
`endif

`ifdef PC_SEQ_SINGLE_STEP_EN
    // no step holds pc; a one-clock step runs exactly one instruction
    do_reset();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    check("step_frozen_pc", pc, 0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    check("step_one_pc", pc, 1);
    check("step_busy", busy, 1);
`endif

    // random programs, random start and step
    for (int it = 0; it < 24; it++) begin
      if (it % 8 == 0) do_reset();
      for (int a = 0; a < NPC; a++) prog[a] = 4'($urandom_range(0, 15));
      for (int c = 0; c < 40; c++)
        tick(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
